// File: rtl/rect_fill_engine.sv
// rect_fill_engine: clipped rectangle fill into the framebuffer write port.
// Solid, checkerboard and full-clear modes with wr_ready back-pressure.
module rect_fill_engine #(
  parameter int FB_WIDTH  = 320,
  parameter int FB_HEIGHT = 240,
  parameter int PIXEL_W   = 8,
  parameter int COORD_W   = 10,
  parameter int ADDR_W    = 17
) (
  input  logic               axi_aclk,
  input  logic               axi_areset,
  input  logic               start,
  input  logic [COORD_W-1:0] x0,
  input  logic [COORD_W-1:0] y0,
  input  logic [COORD_W-1:0] w,
  input  logic [COORD_W-1:0] h,
  input  logic [1:0]         mode,
  input  logic [PIXEL_W-1:0] color_a,
  input  logic [PIXEL_W-1:0] color_b,
  input  logic [3:0]         cell_shift,
  input  logic               wr_ready,
  output logic               wea,
  output logic [ADDR_W-1:0]  addra,
  output logic [PIXEL_W-1:0] dina,
  output logic               busy,
  output logic               done
);

  localparam int CW1 = COORD_W + 1;
  localparam logic [CW1-1:0] FBW = CW1'(FB_WIDTH);
  localparam logic [CW1-1:0] FBH = CW1'(FB_HEIGHT);
  localparam logic [ADDR_W-1:0] FBW_A = ADDR_W'(FB_WIDTH);

  typedef enum logic [1:0] {
    S_IDLE, S_SETUP, S_WRITE, S_DONE
  } state_t;

  state_t             state_q;
  logic [COORD_W-1:0] x0_q, y0_q, w_q, h_q;
  logic [1:0]         mode_q;
  logic [PIXEL_W-1:0] ca_q, cb_q;
  logic [3:0]         cs_q;
  logic [CW1-1:0]     xe_q, ye_q;
  logic [COORD_W-1:0] x_q, y_q;
  logic [ADDR_W-1:0]  rb_q;
  logic               wea_q, busy_q, done_q;
  logic [ADDR_W-1:0]  addra_q;
  logic [PIXEL_W-1:0] dina_q;

  logic [CW1-1:0]     xs_d, ys_d, xe_d, ye_d;
  logic [COORD_W-1:0] sx0_d, sy0_d;
  logic               empty_d;
  logic [ADDR_W-1:0]  srb_d;
  logic [PIXEL_W-1:0] spix_d;
  logic               last_col_d, last_row_d;
  logic [COORD_W-1:0] nx_d, ny_d;
  logic [ADDR_W-1:0]  nrb_d;
  logic [PIXEL_W-1:0] npix_d;

  assign wea   = wea_q;
  assign addra = addra_q;
  assign dina  = dina_q;
  assign busy  = busy_q;
  assign done  = done_q;

  function automatic logic [PIXEL_W-1:0] pix_f(
    input logic [COORD_W-1:0] px,
    input logic [COORD_W-1:0] py,
    input logic [1:0]         md,
    input logic [3:0]         cs,
    input logic [PIXEL_W-1:0] ca,
    input logic [PIXEL_W-1:0] cb
  );
    logic [COORD_W-1:0] t;
    t = (px >> cs) ^ (py >> cs);
    if (md == 2'd1 && t[0]) return cb;
    return ca;
  endfunction

  // Clip the latched command, apply the full-clear override, find first beat
  always_comb begin
    xs_d  = {1'b0, x0_q} + {1'b0, w_q};
    ys_d  = {1'b0, y0_q} + {1'b0, h_q};
    xe_d  = (xs_d > FBW) ? FBW : xs_d;
    ye_d  = (ys_d > FBH) ? FBH : ys_d;
    sx0_d = x0_q;
    sy0_d = y0_q;
    empty_d = ({1'b0, x0_q} >= FBW) || ({1'b0, y0_q} >= FBH) ||
              (w_q == '0) || (h_q == '0);
    if (mode_q == 2'd2) begin
      sx0_d   = '0;
      sy0_d   = '0;
      xe_d    = FBW;
      ye_d    = FBH;
      empty_d = 1'b0;
    end
    srb_d  = ADDR_W'(sy0_d) * FBW_A;
    spix_d = pix_f(sx0_d, sy0_d, mode_q, cs_q, ca_q, cb_q);
  end

  // Raster stepping: the beat that follows the one currently presented
  always_comb begin
    last_col_d = (({1'b0, x_q} + CW1'(1)) == xe_q);
    last_row_d = (({1'b0, y_q} + CW1'(1)) == ye_q);
    nx_d  = last_col_d ? x0_q : x_q + COORD_W'(1);
    ny_d  = last_col_d ? y_q + COORD_W'(1) : y_q;
    nrb_d = last_col_d ? rb_q + FBW_A : rb_q;
    npix_d = pix_f(nx_d, ny_d, mode_q, cs_q, ca_q, cb_q);
  end

  // Command FSM with registered write-port and status outputs
  always_ff @(posedge axi_aclk or posedge axi_areset) begin
    if (axi_areset) begin
      state_q <= S_IDLE;
      x0_q    <= '0;
      y0_q    <= '0;
      w_q     <= '0;
      h_q     <= '0;
      mode_q  <= '0;
      ca_q    <= '0;
      cb_q    <= '0;
      cs_q    <= '0;
      xe_q    <= '0;
      ye_q    <= '0;
      x_q     <= '0;
      y_q     <= '0;
      rb_q    <= '0;
      wea_q   <= 1'b0;
      addra_q <= '0;
      dina_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            x0_q    <= x0;
            y0_q    <= y0;
            w_q     <= w;
            h_q     <= h;
            mode_q  <= mode;
            ca_q    <= color_a;
            cb_q    <= color_b;
            cs_q    <= cell_shift;
            busy_q  <= 1'b1;
            state_q <= S_SETUP;
          end
        end
        S_SETUP: begin
          x0_q <= sx0_d;
          y0_q <= sy0_d;
          xe_q <= xe_d;
          ye_q <= ye_d;
          if (empty_d) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end else begin
            x_q     <= sx0_d;
            y_q     <= sy0_d;
            rb_q    <= srb_d;
            wea_q   <= 1'b1;
            addra_q <= srb_d + ADDR_W'(sx0_d);
            dina_q  <= spix_d;
            state_q <= S_WRITE;
          end
        end
        S_WRITE: begin
          if (wr_ready) begin
            if (last_col_d && last_row_d) begin
              wea_q   <= 1'b0;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end else begin
              x_q     <= nx_d;
              y_q     <= ny_d;
              rb_q    <= nrb_d;
              addra_q <= nrb_d + ADDR_W'(nx_d);
              dina_q  <= npix_d;
            end
          end
        end
        S_DONE: begin
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rect_fill_engine.sv
// Bench for rect_fill_engine: expected writes queued per command,
// a negedge monitor pops and compares every accepted beat.
module tb_rect_fill_engine;

  logic        clk;
  logic        rst;
  logic        start;
  logic [9:0]  x0, y0, w, h;
  logic [1:0]  mode;
  logic [7:0]  color_a, color_b;
  logic [3:0]  cell_shift;
  logic        wr_ready;
  logic        wea;
  logic [16:0] addra;
  logic [7:0]  dina;
  logic        busy;
  logic        done;

  typedef struct packed {
    logic [16:0] a;
    logic [7:0]  d;
  } wr_t;

  wr_t exp_q[$];
  wr_t mon_e;
  int  checks = 0;
  int  errors = 0;

  rect_fill_engine dut (
    .axi_aclk   (clk),
    .axi_areset (rst),
    .start      (start),
    .x0         (x0),
    .y0         (y0),
    .w          (w),
    .h          (h),
    .mode       (mode),
    .color_a    (color_a),
    .color_b    (color_b),
    .cell_shift (cell_shift),
    .wr_ready   (wr_ready),
    .wea        (wea),
    .addra      (addra),
    .dina       (dina),
    .busy       (busy),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic push(input int a, input int d);
    exp_q.push_back('{a: 17'(a), d: 8'(d)});
  endtask

  // Monitor: every accepted beat must match the head of the queue
  always @(negedge clk) begin
    if (!rst && wea && wr_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got addra %0d expected none",
                 addra);
      end else begin
        mon_e = exp_q.pop_front();
        chk("addra", int'(addra), int'(mon_e.a));
        chk("dina", int'(dina), int'(mon_e.d));
      end
    end
  end

  task automatic issue(input int cx0, input int cy0, input int cw,
                       input int ch, input int md, input int ca,
                       input int cb, input int cs);
    @(posedge clk); #1;
    x0 = 10'(cx0);
    y0 = 10'(cy0);
    w  = 10'(cw);
    h  = 10'(ch);
    mode = 2'(md);
    color_a = 8'(ca);
    color_b = 8'(cb);
    cell_shift = 4'(cs);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("busy_setup", int'(busy), 1);
  endtask

  // Runs from cycle N+1; stall_at/ghost_at are relative cycle numbers
  task automatic wait_done(input string nm, input int exp_done,
                           input int stall_at, input int stall_len,
                           input int ghost_at);
    int cnt;
    int limit;
    int busy_bad;
    cnt = 1;
    busy_bad = 0;
    limit = exp_done + 50;
    forever begin
      if (cnt == stall_at) wr_ready = 1'b0;
      if (cnt == stall_at + stall_len) wr_ready = 1'b1;
      if (cnt == ghost_at) begin
        x0 = 10'd0;
        y0 = 10'd0;
        w = 10'd50;
        h = 10'd50;
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
      if (done) break;
      if (cnt >= limit) break;
      if (!busy) busy_bad = 1;
      @(posedge clk); #1;
      cnt++;
    end
    wr_ready = 1'b1;
    start = 1'b0;
    chk({nm, "_done_cycle"}, cnt, exp_done);
    chk({nm, "_busy_window"}, busy_bad, 0);
    chk({nm, "_busy_at_done"}, int'(busy), 0);
    @(posedge clk); #1;
    chk({nm, "_done_pulse"}, int'(done), 0);
    chk({nm, "_left"}, exp_q.size(), 0);
    exp_q.delete();
  endtask

  logic [7:0] ck_tbl [16];

  initial begin
    int cnt;
    ck_tbl = '{8'hFF, 8'hFF, 8'h00, 8'h00,
               8'hFF, 8'hFF, 8'h00, 8'h00,
               8'h00, 8'h00, 8'hFF, 8'hFF,
               8'h00, 8'h00, 8'hFF, 8'hFF};
    rst = 1'b1;
    start = 1'b0;
    x0 = '0;
    y0 = '0;
    w = '0;
    h = '0;
    mode = '0;
    color_a = '0;
    color_b = '0;
    cell_shift = '0;
    wr_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_wea", int'(wea), 0);
    chk("rst_addra", int'(addra), 0);
    chk("rst_dina", int'(dina), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    rst = 1'b0;

    push(3210, 8'hE0);
    push(3211, 8'hE0);
    push(3530, 8'hE0);
    push(3531, 8'hE0);
    issue(10, 10, 2, 2, 0, 8'hE0, 8'h11, 0);
    wait_done("solid", 6, 0, 0, 0);

    push(76798, 8'h1C);
    push(76799, 8'h1C);
    issue(318, 239, 5, 3, 3, 8'h1C, 8'h22, 0);
    wait_done("clip", 4, 0, 0, 0);

    issue(5, 5, 0, 4, 0, 8'h33, 8'h44, 0);
    wait_done("empty_w0", 2, 0, 0, 0);

    issue(320, 5, 4, 4, 0, 8'h33, 8'h44, 0);
    wait_done("empty_x320", 2, 0, 0, 0);

    for (int yy = 0; yy < 4; yy++)
      for (int xx = 0; xx < 4; xx++)
        push(yy * 320 + xx, int'(ck_tbl[yy * 4 + xx]));
    issue(0, 0, 4, 4, 1, 8'hFF, 8'h00, 1);
    wait_done("checker", 18, 0, 0, 0);

    push(16100, 8'h5A);
    push(16101, 8'h5A);
    push(16420, 8'h5A);
    push(16421, 8'h5A);
    issue(100, 50, 2, 2, 0, 8'h5A, 8'h00, 0);
    wait_done("stall", 9, 4, 3, 3);

    for (int i = 0; i < 76800; i++) push(i, 8'h03);
    issue(5, 7, 1, 1, 2, 8'h03, 8'hAA, 0);
    wait_done("clear", 76802, 0, 0, 0);

    for (int yy = 0; yy < 10; yy++)
      for (int xx = 0; xx < 20; xx++)
        push(yy * 320 + xx, 8'h77);
    issue(0, 0, 20, 10, 0, 8'h77, 8'h00, 0);
    cnt = 1;
    while (cnt < 101) begin
      @(posedge clk); #1;
      cnt++;
    end
    rst = 1'b1;
    #1;
    chk("abort_wea", int'(wea), 0);
    chk("abort_busy", int'(busy), 0);
    chk("abort_done", int'(done), 0);
    chk("abort_remaining", exp_q.size(), 101);
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_done", int'(done), 0);

    push(3 * 320 + 7, 8'h42);
    issue(7, 3, 1, 1, 0, 8'h42, 8'h00, 0);
    wait_done("after_rst", 3, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rect_fill_engine.md
# rect_fill_engine

Hardware rectangle-fill unit that drives the framebuffer back-buffer write port (wea/addra/dina) in place of CPU per-pixel writes. It accepts one rectangle command at a time, clips it to the framebuffer, and streams one pixel write per accepted beat. It supports solid, checkerboard and full-clear modes, and honours write back-pressure. It sits between the AXI register block and the double-buffered framebuffer memory.

## Interface
- FB_WIDTH, 320, framebuffer width in pixels
- FB_HEIGHT, 240, framebuffer height in pixels
- PIXEL_W, 8, pixel width (RGB332 = 8)
- COORD_W, 10, width of x/y/w/h command fields
- ADDR_W, 17, write address width (must satisfy 2^ADDR_W ≥ FB_WIDTH*FB_HEIGHT)

Ports:
- axi_aclk  in  1  clock, all logic on rising edge
- axi_areset  in  1  reset; asynchronous and active-high
- start  in  1  command strobe; sampled only in IDLE
- x0, y0  in  COORD_W  top-left corner, in framebuffer pixels
- w, h  in  COORD_W  width and height, in pixels
- mode  in  2  0 = solid, 1 = checker, 2 = full clear, 3 = solid
- color_a, color_b  in  PIXEL_W  primary and secondary colour
- cell_shift  in  4  log2 of the checker cell size
- wr_ready  in  1  framebuffer accepts a write this cycle
- wea  out  1  write valid
- addra  out  ADDR_W  write address = y*FB_WIDTH + x
- dina  out  PIXEL_W  write data
- busy  out  1  command in progress
- done  out  1  one-cycle completion pulse

## Operation
- FSM has four states: IDLE → SETUP → WRITE → DONE → IDLE.
- **IDLE**
  - When start=1, latch all command inputs and go to SETUP.
  - Inputs are ignored in every other state; start while busy is dropped and not queued.
- **SETUP**
  - Clip: xe = min(x0+w, FB_WIDTH), ye = min(y0+h, FB_HEIGHT). Sums are computed at COORD_W+1 bits, so there is no overflow.
  - Mode 2 overrides the command to x0=0, y0=0, xe=FB_WIDTH, ye=FB_HEIGHT, using color_a.
  - Empty area (x0≥FB_WIDTH, y0≥FB_HEIGHT, w=0 or h=0) goes straight to DONE with no writes.
  - Otherwise row_base = y0*FB_WIDTH (constant multiply), x=x0, y=y0, then go to WRITE.
- **WRITE**
  - Drive wea=1, addra=row_base+x, dina=pixel(x,y).
  - A beat transfers when wea & wr_ready.
  - On each transfer, x increments. When x = xe-1: x=x0, y increments, row_base += FB_WIDTH.
  - The transfer at (xe-1, ye-1) moves the FSM to DONE.
  - While wr_ready=0, addra and dina hold stable and wea stays 1.
- **DONE**: done=1 for exactly one cycle, then IDLE.
- Pixel function:
  - Mode 0/2/3: color_a.
  - Mode 1: color_b if ((x>>cell_shift) ^ (y>>cell_shift)) bit 0 is 1, else color_a. x and y are absolute framebuffer coordinates.
- busy = 1 in SETUP and WRITE, 0 in IDLE and DONE.
- Writes go in raster order with no skipped or duplicated addresses.

## Timing
- Reset values: wea=0, addra=0, dina=0, busy=0, done=0, FSM=IDLE, counters=0.
- Reset mid-command aborts immediately (asynchronously). No done pulse; the next start behaves normally.
- Latency with start sampled at edge N and wr_ready held 1:
  - SETUP in cycle N+1.
  - First wea in N+2.
  - Last beat in N+1+P, where P is the clipped pixel count.
  - done in N+2+P.
- Empty area: done in cycle N+2, and wea is never asserted.
- Each wr_ready=0 cycle in WRITE delays completion by exactly one cycle.
- A new start may be sampled in the first IDLE cycle after DONE, i.e. N+3+P.
- Outputs are registered; there are no combinational paths from inputs to wea, addra or dina.

## Test plan
- Solid fill: x0=10, y0=10, w=2, h=2, color_a=0xE0, start at N → wea in N+2..N+5 with addra 3210, 3211, 3530, 3531 and dina 0xE0; done=1 only in N+6; busy=1 in N+1..N+5.
- Clipping: x0=318, y0=239, w=5, h=3 → exactly 2 writes (addra 76798, 76799), then done.
- Empty area:
  - w=0 → no wea, done at N+2.
  - x0=320 → same result.
- Checker: x0=0, y0=0, w=4, h=4, cell_shift=1, A=0xFF, B=0x00 → dina in rows 0–1 is FF,FF,00,00; in rows 2–3 it is 00,00,FF,FF.
- Back-pressure and start while busy:
  - Drop wr_ready for 3 cycles at the 3rd beat of a 2×2 fill → addra/dina held, 4 unique addresses written, done at N+9.
  - start pulsed while busy → ignored.
- Full clear and reset:
  - mode=2, color_a=0x03 → 76800 writes at addresses 0..76799, done at N+76802.
  - Assert axi_areset at beat 100 → wea, busy and done go to 0 at once; a following 1×1 command completes normally.
